lbp_stream: RTL and testbench

LBP_STREAM -- requirements
Module: lbp_stream

---
 rtl/lbp_stream_if.sv | 24 ++
 rtl/lbp_stream.sv | 204 ++++++++++++++++++++
 tb/tb_lbp_stream.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/lbp_stream_if.sv
// Pixel-source read port and LBP result port of lbp_stream.
// The master side is the LBP engine; the slave side is the pixel source / result sink.
interface lbp_stream_if #(
  parameter int DW = 8,
  parameter int AW = 14
);
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          gray_ready;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;

  modport master (
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
    input  gray_data, gray_ready
  );

  modport slave (
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
    output gray_data, gray_ready
  );
endinterface

// File: rtl/lbp_stream.sv
// Streaming 3x3 local-binary-pattern engine: raster-reads a gray image once through
// two line buffers and emits one 8-bit LBP code per output center, in raster order.
module lbp_stream #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          border_mode,
  input  logic [DW-1:0] thresh,
  output logic          busy,
  output logic          finish,
  lbp_stream_if.master  bus
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam int LW = $clog2(IMG_W);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H);
  localparam logic [XW-1:0] X_HI   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_HI   = YW'(IMG_H - 1);
  localparam logic [AW-1:0] STRIDE = AW'(IMG_W);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  // One window column: [0] = upper row, [1] = middle row, [2] = lower row.
  typedef logic [2:0][DW-1:0] col_t;

  function automatic logic ge_bit(input logic [DW-1:0] n, input logic [DW-1:0] c,
                                  input logic [DW-1:0] t);
    return {1'b0, n} >= ({1'b0, c} + {1'b0, t});
  endfunction

  function automatic logic [7:0] lbp_code(input col_t l, input col_t m, input col_t r,
                                          input logic [DW-1:0] t);
    logic [DW-1:0] c;
    c = m[1];
    return {ge_bit(r[2], c, t), ge_bit(m[2], c, t), ge_bit(l[2], c, t), ge_bit(r[1], c, t),
            ge_bit(l[1], c, t), ge_bit(r[0], c, t), ge_bit(m[0], c, t), ge_bit(l[0], c, t)};
  endfunction

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] thresh_q, thresh_d;
  logic          drain_q, drain_d;
  logic          is_real, adv;

  logic          vld_p1_q, vld_p1_d;
  logic          real_p1_q, real_p1_d;
  logic [XW-1:0] x_p1_q, x_p1_d;
  logic [YW-1:0] y_p1_q, y_p1_d;

  col_t          col_m1_q, col_m1_d;
  col_t          col_m2_q, col_m2_d;
  col_t          col_new;
  logic [DW-1:0] lb0_q [IMG_W];
  logic [DW-1:0] lb1_q [IMG_W];
  logic [DW-1:0] pix, lb0_rd, lb1_rd;
  logic [LW-1:0] xi;
  logic          lb_we, out_ok;

  logic          lbp_valid_q, lbp_valid_d;
  logic [AW-1:0] lbp_addr_q, lbp_addr_d;
  logic [7:0]    lbp_data_q, lbp_data_d;

  // ---- stage p0: scan position issue and frame control
  assign is_real = (x_q != X_LAST) && (y_q != Y_LAST);
  assign adv     = (state_q == SCAN) && (!is_real || bus.gray_ready);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    addr_d   = addr_q;
    mode_d   = mode_q;
    thresh_d = thresh_q;
    drain_d  = drain_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = SCAN;
          x_d      = '0;
          y_d      = '0;
          addr_d   = '0;
          mode_d   = border_mode;
          thresh_d = thresh;
        end
      end
      SCAN: begin
        if (adv) begin
          if (is_real) addr_d = addr_q + 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              state_d = DRAIN;
              drain_d = 1'b0;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign vld_p1_d  = adv;
  assign real_p1_d = is_real;
  assign x_p1_d    = x_q;
  assign y_p1_d    = y_q;

  // ---- stage p1: read data arrives, window shifts, code is formed
  always_comb begin
    xi     = x_p1_q[LW-1:0];
    pix    = real_p1_q ? bus.gray_data : '0;
    lb0_rd = lb0_q[xi];
    lb1_rd = lb1_q[xi];
    lb_we  = vld_p1_q && (x_p1_q != X_LAST);
    // The virtual column is all padding; rows above the image read as zero.
    col_new = '0;
    if (x_p1_q != X_LAST) begin
      col_new[0] = (y_p1_q >= YW'(2)) ? lb0_rd : '0;
      col_new[1] = (y_p1_q >= YW'(1)) ? lb1_rd : '0;
      col_new[2] = pix;
    end
    col_m1_d = vld_p1_q ? col_new  : col_m1_q;
    col_m2_d = vld_p1_q ? col_m1_q : col_m2_q;
    // Window centered at (x_p1-1, y_p1-1).
    if (mode_q)
      out_ok = (x_p1_q >= XW'(1)) && (y_p1_q >= YW'(1));
    else
      out_ok = (x_p1_q >= XW'(2)) && (x_p1_q <= X_HI) &&
               (y_p1_q >= YW'(2)) && (y_p1_q <= Y_HI);
    lbp_valid_d = vld_p1_q && out_ok;
    lbp_addr_d  = lbp_addr_q;
    lbp_data_d  = lbp_data_q;
    if (lbp_valid_d) begin
      lbp_addr_d = AW'(y_p1_q - 1'b1) * STRIDE + AW'(x_p1_q - 1'b1);
      lbp_data_d = lbp_code(col_m2_q, col_m1_q, col_new, thresh_q);
    end
  end

  // ---- stage p2: registered result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      mode_q      <= 1'b0;
      thresh_q    <= '0;
      drain_q     <= 1'b0;
      vld_p1_q    <= 1'b0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      mode_q      <= mode_d;
      thresh_q    <= thresh_d;
      drain_q     <= drain_d;
      vld_p1_q    <= vld_p1_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
    end
  end

  always_ff @(posedge clk) begin
    real_p1_q <= real_p1_d;
    x_p1_q    <= x_p1_d;
    y_p1_q    <= y_p1_d;
    col_m1_q  <= col_m1_d;
    col_m2_q  <= col_m2_d;
    if (lb_we) begin
      lb0_q[xi] <= lb1_rd;
      lb1_q[xi] <= pix;
    end
  end

  assign bus.gray_req  = (state_q == SCAN) && is_real && bus.gray_ready;
  assign bus.gray_addr = addr_q;
  assign bus.lbp_valid = lbp_valid_q;
  assign bus.lbp_addr  = lbp_addr_q;
  assign bus.lbp_data  = lbp_data_q;
  assign busy          = (state_q == SCAN) || (state_q == DRAIN);
  assign finish        = (state_q == DONE);

endmodule

// File: tb/tb_lbp_stream.sv
// Bench for lbp_stream on a 4x4 image: directed and randomized frames checked against
// a neighbourhood-level LBP model, plus read-order, latency, stall and reset checks.
module tb_lbp_stream;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int AW = 14;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          border_mode;
  logic [DW-1:0] thresh;
  logic          busy;
  logic          finish;

  lbp_stream_if #(.DW(DW), .AW(AW)) bus ();

  lbp_stream #(.IMG_W(W), .IMG_H(H), .DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .border_mode (border_mode),
    .thresh      (thresh),
    .busy        (busy),
    .finish      (finish),
    .bus         (bus.master)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] img [N];
  int         edge_n   = 0;
  int         stall_lo = -100;
  int         smode    = 0;
  bit         pend     = 1'b0;
  int         pend_idx = 0;
  int         rd_q[$];
  int         res_addr[$];
  int         res_data[$];
  int         res_edge[$];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  // Pixel source: answers a read one cycle later; garbage on the bus otherwise.
  initial begin
    bus.gray_ready = 1'b1;
    bus.gray_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.gray_data  = pend ? img[pend_idx] : DW'($urandom);
      bus.gray_ready = !(edge_n >= stall_lo && edge_n < stall_lo + 5) &&
                       (smode == 0 || $urandom_range(0, 2) != 0);
    end
  end

  initial forever begin
    @(negedge clk);
    pend     = bus.gray_req;
    pend_idx = int'(bus.gray_addr);
    if (bus.gray_req) rd_q.push_back(int'(bus.gray_addr));
    if (bus.lbp_valid) begin
      res_addr.push_back(int'(bus.lbp_addr));
      res_data.push_back(int'(bus.lbp_data));
      res_edge.push_back(edge_n);
    end
    if (busy && !bus.gray_ready) check("req_low_when_not_ready", bus.gray_req, 0);
  end

  function automatic int px(input int x, input int y);
    if (x < 0 || y < 0 || x >= W || y >= H) return 0;
    return int'(img[y * W + x]);
  endfunction

  function automatic int ref_code(input int cx, input int cy, input int th);
    int dx[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int dy[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int code = 0;
    for (int k = 0; k < 8; k++)
      if (px(cx + dx[k], cy + dy[k]) >= px(cx, cy) + th) code |= (1 << k);
    return code;
  endfunction

  // Runs one frame and compares everything it produced with the model.
  task automatic run_frame(input bit mode, input int th, input int sm, input bit timing,
                           input bit stall5, input bit inj, input string nm);
    int s_edge, cyc;
    int exp_addr[$], exp_data[$], exp_edge[$];
    int m;
    res_addr.delete(); res_data.delete(); res_edge.delete(); rd_q.delete();
    smode = sm;
    @(negedge clk);
    start = 1'b1; border_mode = mode; thresh = DW'(th);
    @(posedge clk);
    #1;
    start = 1'b0; border_mode = ~mode; thresh = ~thresh;
    s_edge = edge_n;
    if (stall5) stall_lo = s_edge + 6;
    check({nm, "_busy_finish_at_start"}, {busy, finish}, 2'b10);
    cyc = 0;
    while (finish !== 1'b1 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = inj && (cyc == 5);
    end
    start = 1'b0;
    stall_lo = -100;
    check({nm, "_finish"}, finish, 1);
    check({nm, "_busy_after"}, busy, 0);
    if (timing) check({nm, "_latency"}, cyc, (W + 1) * (H + 1) + 2);
    for (int cy = 0; cy < H; cy++)
      for (int cx = 0; cx < W; cx++)
        if (mode || (cx >= 1 && cx <= W - 2 && cy >= 1 && cy <= H - 2)) begin
          exp_addr.push_back(cy * W + cx);
          exp_data.push_back(ref_code(cx, cy, th));
          exp_edge.push_back((cy + 1) * (W + 1) + (cx + 1) + 2);
        end
    check({nm, "_count"}, res_addr.size(), exp_addr.size());
    m = (res_addr.size() < exp_addr.size()) ? res_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_addr%0d", nm, i), res_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", nm, i), res_data[i], exp_data[i]);
      if (timing) check($sformatf("%s_when%0d", nm, i), res_edge[i] - s_edge, exp_edge[i]);
    end
    check({nm, "_reads"}, rd_q.size(), N);
    for (int i = 0; i < rd_q.size() && i < N; i++)
      check($sformatf("%s_rd%0d", nm, i), rd_q[i], i);
  endtask

  initial begin
    start = 1'b0; border_mode = 1'b0; thresh = '0; reset = 1'b0;
    #2 reset = 1'b1;
    #1 check("reset_outputs", {bus.gray_req, bus.gray_addr, bus.lbp_valid, bus.lbp_addr,
                               bus.lbp_data, busy, finish}, 0);
    repeat (3) @(posedge clk);
    #1 check("reset_outputs_held", {bus.gray_req, bus.gray_addr, bus.lbp_valid, bus.lbp_addr,
                                    bus.lbp_data, busy, finish}, 0);
    @(negedge clk) reset = 1'b0;

    // Flat image, interior only: four 0xFF codes
    for (int i = 0; i < N; i++) img[i] = 8'd50;
    run_frame(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, "flat_m0");
    if (res_data.size() == 4) begin
      check("flat_m0_first_ff", res_data[0], 8'hFF);
      check("flat_m0_last_addr", res_addr[3], 10);
    end

    // Flat image, zero-padded borders
    run_frame(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, "flat_m1");
    if (res_data.size() == 16) begin
      check("flat_m1_corner0", res_data[0], 8'hD0);
      check("flat_m1_corner15", res_data[15], 8'h0B);
      check("flat_m1_center5", res_data[5], 8'hFF);
    end
    repeat (4) @(posedge clk);
    #1 check("finish_sticky", finish, 1);

    // Threshold edges
    for (int i = 0; i < N; i++) img[i] = 8'd110;
    img[5] = 8'd100;
    run_frame(1'b0, 10, 0, 1'b0, 1'b0, 1'b0, "th10");
    if (res_data.size() > 0) check("th10_center", res_data[0], 8'hFF);
    run_frame(1'b0, 11, 0, 1'b0, 1'b0, 1'b0, "th11");
    if (res_data.size() > 0) check("th11_center", res_data[0], 8'h00);
    img[5] = 8'd255;
    run_frame(1'b0, 255, 0, 1'b0, 1'b0, 1'b0, "th255");
    if (res_data.size() > 0) check("th255_center", res_data[0], 8'h00);

    // Five-cycle ready stall in the middle of a row
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    run_frame(1'b1, 3, 0, 1'b0, 1'b1, 1'b0, "stall5");

    // Random images, modes, thresholds and ready patterns
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) img[i] = 8'($urandom);
      run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 40), 1, 1'b0, 1'b0, 1'b0,
                $sformatf("rand%0d", r));
    end

    // Start pulse during a frame must not disturb it
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    run_frame(1'b1, 7, 0, 1'b1, 1'b0, 1'b1, "start_busy");

    // Reset in the middle of a scan, then a clean frame
    @(negedge clk);
    start = 1'b1; border_mode = 1'b1; thresh = 8'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #3 reset = 1'b1;
    #1 check("reset_mid_async", {bus.gray_req, bus.gray_addr, bus.lbp_valid, bus.lbp_addr,
                                 bus.lbp_data, busy, finish}, 0);
    repeat (2) @(posedge clk);
    #1 check("reset_mid_held", {bus.gray_req, bus.gray_addr, bus.lbp_valid, bus.lbp_addr,
                                bus.lbp_data, busy, finish}, 0);
    @(negedge clk) reset = 1'b0;
    run_frame(1'b1, 5, 0, 1'b1, 1'b0, 1'b0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
